// File: rtl/avalon_pkg.sv
// Shared Avalon-ST message-path types and length helpers.
// Used by transmit-side framers and the receive-side checker alike.
// Purely declarative: no ports, no state.
package avalon_pkg;

    // Message framing state, common to the framer and the checker.
    typedef enum logic {
        IN_MSG      = 1'b0,
        BETWEEN_MSG = 1'b1
    } msg_sm_t;

    // Number of beats needed to carry len bytes at bpb bytes per beat.
    function automatic int unsigned calc_words(input int unsigned len,
                                               input int unsigned bpb);
        return (len + bpb - 1) / bpb;
    endfunction

    // Unused bytes in the final beat of a len-byte message.
    function automatic int unsigned calc_empty(input int unsigned len,
                                               input int unsigned bpb);
        return calc_words(len, bpb) * bpb - len;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: valid/rdy handshake with sop, eop, empty, data.
// Pure wiring; the master drives everything except rdy.
// Downstream stalls the master by holding rdy low.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;

    modport master (output valid, sop, eop, empty, data, input rdy);
    modport slave  (input valid, sop, eop, empty, data, output rdy);
endinterface

// File: rtl/avalon_st_out_reg.sv
// Single-entry Avalon-ST output register with valid/rdy hold.
// Latency: one cycle from load to valid.
// Backpressure: fields held stable while valid & ~rdy; can_load = ~valid | rdy.
// Ports: clk, rst (async active-low); load + load_* fields in; rdy in;
//        can_load, valid, sop, eop, empty, data out (all registered except can_load).
module avalon_st_out_reg #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int EMPTY_W             = $clog2(DATA_WIDTH_IN_BYTES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             load_sop,
    input  logic                             load_eop,
    input  logic [EMPTY_W-1:0]               load_empty,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] load_data,
    input  logic                             rdy,
    output logic                             can_load,
    output logic                             valid,
    output logic                             sop,
    output logic                             eop,
    output logic [EMPTY_W-1:0]               empty,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] data
);
    // Space exists when empty or draining this cycle; allows drain+load together.
    assign can_load = ~valid | rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            empty <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            sop   <= load_sop;
            eop   <= load_eop;
            empty <= load_empty;
            data  <= load_data;
        end else if (rdy) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/avalon_packetizer.sv
// Frames a length request plus raw word stream into Avalon-ST messages (sop/eop/empty).
// Latency: one cycle from raw handshake to msg_out.valid; >=1 bubble between messages.
// Backpressure: raw_rdy drops while the output beat is stalled; msg_out.rdy may toggle freely.
// Ports: clk, rst (async active-low); len_valid/len_rdy/len_bytes request;
//        raw_valid/raw_rdy/raw_data payload; msg_out framed stream;
//        zero_len_indi / oversize_indi one-cycle drop pulses.
// Optional: AVALON_PACKETIZER_MSG_CNT_EN adds msg_cnt (eop beats accepted, wraps)
//           and drop_cnt (dropped requests, saturating).
module avalon_packetizer
    import avalon_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BYTES       = 4096,
    parameter int LEN_W               = $clog2(MAX_MSG_BYTES + 1) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             len_valid,
    output logic                             len_rdy,
    input  logic [LEN_W-1:0]                 len_bytes,
    input  logic                             raw_valid,
    output logic                             raw_rdy,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] raw_data,
    avalon_st_if.master                      msg_out,
    output logic                             zero_len_indi,
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
    output logic [31:0]                      msg_cnt,
    output logic [15:0]                      drop_cnt,
`endif
    output logic                             oversize_indi
);
    localparam int          DW        = DATA_WIDTH_IN_BYTES * 8;
    localparam int unsigned BPB       = DATA_WIDTH_IN_BYTES;
    localparam int          MAX_WORDS = (MAX_MSG_BYTES + DATA_WIDTH_IN_BYTES - 1) / DATA_WIDTH_IN_BYTES;
    localparam int          WORDS_W   = $clog2(MAX_WORDS + 1);
    localparam int          EMPTY_W   = $clog2(DATA_WIDTH_IN_BYTES);

    msg_sm_t              state;
    logic [WORDS_W-1:0]   words_left;
    logic [EMPTY_W-1:0]   last_empty;
    logic                 first_flag;

    logic                 can_load;
    logic                 len_hs;
    logic                 raw_hs;
    logic                 len_zero;
    logic                 len_over;
    logic                 last_word;
    logic [EMPTY_W-1:0]   ld_empty;
    logic [DW-1:0]        keep_mask;
    logic [DW-1:0]        ld_data;

    assign len_rdy   = (state == BETWEEN_MSG);
    assign raw_rdy   = (state == IN_MSG) & can_load;
    assign len_hs    = len_valid & len_rdy;
    assign raw_hs    = raw_valid & raw_rdy;
    assign len_zero  = (len_bytes == '0);
    assign len_over  = (len_bytes > LEN_W'(MAX_MSG_BYTES));
    assign last_word = (words_left == WORDS_W'(1));

    // Trailing empty bytes sit in the LSBs (first byte is in the MSBs); force them to zero.
    assign ld_empty  = last_word ? last_empty : '0;
    assign keep_mask = {DW{1'b1}} << {ld_empty, 3'b000};
    assign ld_data   = raw_data & keep_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BETWEEN_MSG;
            words_left    <= '0;
            last_empty    <= '0;
            first_flag    <= 1'b0;
            zero_len_indi <= 1'b0;
            oversize_indi <= 1'b0;
        end else begin
            zero_len_indi <= 1'b0;
            oversize_indi <= 1'b0;
            case (state)
                BETWEEN_MSG: begin
                    if (len_hs) begin
                        if (len_zero) begin
                            zero_len_indi <= 1'b1;
                        end else if (len_over) begin
                            oversize_indi <= 1'b1;
                        end else begin
                            words_left <= WORDS_W'(calc_words(32'(len_bytes), BPB));
                            last_empty <= EMPTY_W'(calc_empty(32'(len_bytes), BPB));
                            first_flag <= 1'b1;
                            state      <= IN_MSG;
                        end
                    end
                end
                IN_MSG: begin
                    if (raw_hs) begin
                        first_flag <= 1'b0;
                        words_left <= words_left - WORDS_W'(1);
                        if (last_word) begin
                            state <= BETWEEN_MSG;
                        end
                    end
                end
                default: state <= BETWEEN_MSG;
            endcase
        end
    end

    avalon_st_out_reg #(
        .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES),
        .EMPTY_W             (EMPTY_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (raw_hs),
        .load_sop   (first_flag),
        .load_eop   (last_word),
        .load_empty (ld_empty),
        .load_data  (ld_data),
        .rdy        (msg_out.rdy),
        .can_load   (can_load),
        .valid      (msg_out.valid),
        .sop        (msg_out.sop),
        .eop        (msg_out.eop),
        .empty      (msg_out.empty),
        .data       (msg_out.data)
    );

`ifdef AVALON_PACKETIZER_MSG_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (msg_out.valid & msg_out.rdy & msg_out.eop) begin
                msg_cnt <= msg_cnt + 32'd1;
            end
            if (len_hs & (len_zero | len_over) & (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avalon_packetizer.sv
// Self-checking bench for avalon_packetizer: scoreboard of expected beats,
// scenario tasks for single beat, partial last beat, stalls, drops,
// back-to-back framing, mid-message reset and random rdy toggling.
module tb_avalon_packetizer;
    localparam int BPB   = 16;
    localparam int DW    = BPB * 8;
    localparam int LEN_W = 14;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [3:0]    empty;
        logic [DW-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             len_valid = 1'b0;
    logic             len_rdy;
    logic [LEN_W-1:0] len_bytes = '0;
    logic             raw_valid = 1'b0;
    logic             raw_rdy;
    logic [DW-1:0]    raw_data = '0;
    logic             zero_len_indi;
    logic             oversize_indi;
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
    logic [31:0]      msg_cnt;
    logic [15:0]      drop_cnt;
`endif

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(BPB)) msg_if ();

    always #5 clk = ~clk;

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES (BPB),
        .MAX_MSG_BYTES       (4096),
        .LEN_W               (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .len_valid     (len_valid),
        .len_rdy       (len_rdy),
        .len_bytes     (len_bytes),
        .raw_valid     (raw_valid),
        .raw_rdy       (raw_rdy),
        .raw_data      (raw_data),
        .msg_out       (msg_if),
        .zero_len_indi (zero_len_indi),
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
        .msg_cnt       (msg_cnt),
        .drop_cnt      (drop_cnt),
`endif
        .oversize_indi (oversize_indi)
    );

    beat_t exp_q[$];
    int    beat_cycles[$];
    beat_t cur_exp;
    beat_t last_beat;
    beat_t prev_out;
    logic  prev_hold = 1'b0;
    bit    len_hs, raw_hs, rnd_rdy;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    beats = 0;

    // Expected beat idx of a len-byte message carrying word d.
    function automatic beat_t make_exp(input int len, input int idx, input logic [DW-1:0] d);
        beat_t b;
        int nw;
        nw      = (len + BPB - 1) / BPB;
        b.sop   = (idx == 0);
        b.eop   = (idx == nw - 1);
        b.empty = b.eop ? 4'(nw * BPB - len) : 4'd0;
        b.data  = d;
        if (b.eop) begin
            for (int k = 0; k < BPB; k++) begin
                if (k >= BPB - int'(b.empty)) b.data[DW-1-8*k -: 8] = 8'h00;
            end
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] pat(input int base, input int idx);
        logic [DW-1:0] w;
        for (int k = 0; k < BPB; k++) w[DW-1-8*k -: 8] = 8'(base + idx * BPB + k);
        return w;
    endfunction

    // One clock: observe at negedge (scoreboard pop/compare, hold check,
    // record handshakes), then advance to just after the next posedge.
    task automatic step();
        beat_t obs;
        beat_t e;
        @(negedge clk);
        obs = {msg_if.sop, msg_if.eop, msg_if.empty, msg_if.data};
        if (prev_hold) begin
            n_cmp++;
            if (!msg_if.valid || obs !== prev_out) begin
                n_fail++;
                $display("FAIL hold_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                         msg_if.valid, obs, prev_out);
            end
        end
        prev_hold = msg_if.valid && !msg_if.rdy;
        prev_out  = obs;
        len_hs    = len_valid && len_rdy;
        raw_hs    = raw_valid && raw_rdy;
        if (msg_if.valid && msg_if.rdy) begin
            beats++;
            beat_cycles.push_back(cyc);
            last_beat = obs;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got beat=%h, required no beat", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL beat: got sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                             obs.sop, obs.eop, obs.empty, obs.data, e.sop, e.eop, e.empty, e.data);
                end
            end
        end
        if (raw_hs) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_rdy) msg_if.rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send_len(input int len);
        len_valid = 1'b1;
        len_bytes = LEN_W'(len);
        len_hs    = 1'b0;
        for (int i = 0; i < 20 && !len_hs; i++) step();
        len_valid = 1'b0;
        n_cmp++;
        if (!len_hs) begin
            n_fail++;
            $display("FAIL len_accept: got no handshake for len=%0d, required one within 20 cycles", len);
        end
    endtask

    task automatic send_word(input int len, input int idx, input logic [DW-1:0] d);
        raw_valid = 1'b1;
        raw_data  = d;
        cur_exp   = make_exp(len, idx, d);
        raw_hs    = 1'b0;
        for (int i = 0; i < 50 && !raw_hs; i++) step();
        raw_valid = 1'b0;
        n_cmp++;
        if (!raw_hs) begin
            n_fail++;
            $display("FAIL raw_accept: got no handshake for word %0d, required one within 50 cycles", idx);
        end
    endtask

    task automatic send_msg(input int len, input int base);
        send_len(len);
        for (int idx = 0; idx < (len + BPB - 1) / BPB; idx++) send_word(len, idx, pat(base, idx));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || msg_if.valid); i++) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        msg_if.rdy = 1'b1;
        rst = 1'b0;
        #12;
        n_cmp++;
        if (msg_if.valid !== 1'b0 || msg_if.sop !== 1'b0 || msg_if.eop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/sop/eop=%b%b%b, required 000", msg_if.valid, msg_if.sop, msg_if.eop);
        end
        n_cmp++;
        if (msg_if.empty !== 4'd0 || msg_if.data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got empty=%0d data=%h, required 0/0", msg_if.empty, msg_if.data);
        end
        n_cmp++;
        if (zero_len_indi !== 1'b0 || oversize_indi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_indi: got zero=%b over=%b, required 0/0", zero_len_indi, oversize_indi);
        end
        n_cmp++;
        if (len_rdy !== 1'b1 || raw_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy: got len_rdy=%b raw_rdy=%b, required 1/0", len_rdy, raw_rdy);
        end
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
        n_cmp++;
        if (msg_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got msg_cnt=%0d drop_cnt=%0d, required 0/0", msg_cnt, drop_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        int b0;
        logic [DW-1:0] want;
        want = 128'h000102030405060708090A0B0C0D0E0F;
        b0 = beats;
        send_msg(16, 0);
        drain();
        n_cmp++;
        if (beats - b0 != 1 || last_beat !== {1'b1, 1'b1, 4'd0, want}) begin
            n_fail++;
            $display("FAIL single_beat: got %0d beats last=%h, required 1 beat sop=eop=1 empty=0 data=%h",
                     beats - b0, last_beat, want);
        end
    endtask

    task automatic test_partial_last();
        int b0;
        logic [DW-1:0] aa;
        logic [DW-1:0] want;
        aa   = {16{8'hAA}};
        want = {{5{8'hAA}}, 88'h0};
        b0 = beats;
        send_len(37);
        for (int i = 0; i < 3; i++) send_word(37, i, aa);
        drain();
        n_cmp++;
        if (beats - b0 != 3) begin
            n_fail++;
            $display("FAIL partial_count: got %0d beats, required 3", beats - b0);
        end
        n_cmp++;
        if (last_beat.empty !== 4'd11 || last_beat.data !== want || last_beat.eop !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_last: got empty=%0d eop=%b data=%h, required 11/1/%h",
                     last_beat.empty, last_beat.eop, last_beat.data, want);
        end
    endtask

    task automatic test_backpressure();
        int b0;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        w1 = pat(8'h30, 1);
        w2 = pat(8'h30, 2);
        b0 = beats;
        msg_if.rdy = 1'b1;
        send_len(48);
        send_word(48, 0, pat(8'h30, 0));
        send_word(48, 1, w1);
        msg_if.rdy = 1'b0;
        raw_valid  = 1'b1;
        raw_data   = w2;
        cur_exp    = make_exp(48, 2, w2);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (raw_rdy !== 1'b0 || msg_if.valid !== 1'b1 || msg_if.data !== w1) begin
                n_fail++;
                $display("FAIL stall_hold: got raw_rdy=%b valid=%b data=%h, required 0/1/%h",
                         raw_rdy, msg_if.valid, msg_if.data, w1);
            end
        end
        msg_if.rdy = 1'b1;
        raw_valid  = 1'b0;
        send_word(48, 2, w2);
        drain();
        n_cmp++;
        if (beats - b0 != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats, required 3", beats - b0);
        end
    endtask

    task automatic test_drops();
        msg_if.rdy = 1'b1;
        send_len(0);
        n_cmp++;
        if (zero_len_indi !== 1'b1 || oversize_indi !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse: got zero=%b over=%b, required 1/0", zero_len_indi, oversize_indi);
        end
        step();
        n_cmp++;
        if (zero_len_indi !== 1'b0 || msg_if.valid !== 1'b0 || raw_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got zero=%b valid=%b raw_rdy=%b, required 0/0/0",
                     zero_len_indi, msg_if.valid, raw_rdy);
        end
        send_len(4097);
        n_cmp++;
        if (oversize_indi !== 1'b1 || zero_len_indi !== 1'b0) begin
            n_fail++;
            $display("FAIL over_pulse: got over=%b zero=%b, required 1/0", oversize_indi, zero_len_indi);
        end
        step();
        n_cmp++;
        if (oversize_indi !== 1'b0 || msg_if.valid !== 1'b0 || raw_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL over_after: got over=%b valid=%b raw_rdy=%b, required 0/0/0",
                     oversize_indi, msg_if.valid, raw_rdy);
        end
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
        n_cmp++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d, required 2", drop_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int b0;
        b0 = beats;
        beat_cycles.delete();
        msg_if.rdy = 1'b1;
        send_msg(16, 8'h10);
        send_msg(32, 8'h40);
        drain();
        n_cmp++;
        if (beats - b0 != 3 || beat_cycles.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats, required 3", beats - b0);
        end else begin
            n_cmp++;
            if (beat_cycles[1] - beat_cycles[0] != 2 || beat_cycles[2] - beat_cycles[1] != 1) begin
                n_fail++;
                $display("FAIL b2b_gap: got gaps %0d/%0d, required 2/1",
                         beat_cycles[1] - beat_cycles[0], beat_cycles[2] - beat_cycles[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        msg_if.rdy = 1'b1;
        send_len(64);
        send_word(64, 0, pat(8'h50, 0));
        send_word(64, 1, pat(8'h50, 1));
        rst = 1'b0;
        #1;
        n_cmp++;
        if (msg_if.valid !== 1'b0 || msg_if.sop !== 1'b0 || msg_if.eop !== 1'b0 ||
            msg_if.empty !== 4'd0 || msg_if.data !== '0) begin
            n_fail++;
            $display("FAIL midreset_out: got valid=%b sop=%b eop=%b empty=%0d data=%h, required all 0",
                     msg_if.valid, msg_if.sop, msg_if.eop, msg_if.empty, msg_if.data);
        end
        n_cmp++;
        if (len_rdy !== 1'b1 || raw_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rdy: got len_rdy=%b raw_rdy=%b, required 1/0", len_rdy, raw_rdy);
        end
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        b0 = beats;
        send_msg(16, 8'h80);
        drain();
        n_cmp++;
        if (beats - b0 != 1 || last_beat.sop !== 1'b1 || last_beat.eop !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_new: got %0d beats sop=%b eop=%b, required 1 beat sop=eop=1",
                     beats - b0, last_beat.sop, last_beat.eop);
        end
`ifdef AVALON_PACKETIZER_MSG_CNT_EN
        n_cmp++;
        if (msg_cnt !== 32'd1 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_cnt: got msg_cnt=%0d drop_cnt=%0d, required 1/0", msg_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int b0;
        int nw_total;
        int len;
        b0 = beats;
        nw_total = 0;
        rnd_rdy = 1'b1;
        for (int m = 0; m < 8; m++) begin
            len = $urandom_range(1, 100);
            nw_total += (len + BPB - 1) / BPB;
            send_msg(len, m * 16);
        end
        rnd_rdy = 1'b0;
        msg_if.rdy = 1'b1;
        drain();
        n_cmp++;
        if (beats - b0 != nw_total) begin
            n_fail++;
            $display("FAIL random_count: got %0d beats, required %0d", beats - b0, nw_total);
        end
    endtask

    initial begin
        msg_if.rdy = 1'b1;
        rnd_rdy = 1'b0;
        test_reset();
        test_single_beat();
        test_partial_last();
        test_backpressure();
        test_drops();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_packetizer.md
Name: avalon_packetizer

Overview:
- Transmit-side framer for the Avalon-ST message path: turns a length request plus a raw, unframed word stream into well-formed Avalon-ST messages with sop, eop and empty.
- Output is by construction legal for downstream checkers: no missing or unexpected sop, and empty bytes are zeroed.
- Sits upstream of the message consumers, between software/DMA-fed raw word sources and the Avalon-ST fabric.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, bytes per beat; data width is DATA_WIDTH_IN_BYTES*8.
- MAX_MSG_BYTES, 4096, largest legal message length in bytes.
- LEN_W, $clog2(MAX_MSG_BYTES+1)+1 (derived), width of len_bytes; one extra bit so oversize requests are representable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- len_valid  in  1  length request valid
- len_rdy  out  1  length request accepted
- len_bytes  in  LEN_W  message length in bytes
- raw_valid  in  1  raw payload word valid
- raw_rdy  out  1  raw payload word accepted
- raw_data  in  DATA_WIDTH_IN_BYTES*8  payload word; first byte in MSBs
- msg_out  avalon_st_if.master  -  framed output: valid, rdy, sop, eop, empty, data
- zero_len_indi  out  1  one-cycle pulse: len_bytes==0 request dropped
- oversize_indi  out  1  one-cycle pulse: len_bytes>MAX_MSG_BYTES request dropped

Behaviour:
- Reset (rst low, async): state=BETWEEN_MSG; msg_out.valid/sop/eop=0; empty=0; data=0; both indis=0; counters=0. Reset mid-message abandons the partial message with no eop emitted.
- States:
  - BETWEEN_MSG: len_rdy=1, raw_rdy=0.
  - IN_MSG: len_rdy=0, raw_rdy = ~msg_out.valid | msg_out.rdy.
- Length handshake (len_valid & len_rdy):
  - len==0: pulse zero_len_indi; stay in BETWEEN_MSG.
  - len>MAX_MSG_BYTES: pulse oversize_indi; stay in BETWEEN_MSG.
  - Otherwise: words_left=ceil(len/DATA_WIDTH_IN_BYTES); last_empty=words*DATA_WIDTH_IN_BYTES-len; first_flag=1; go to IN_MSG.
- Raw handshake (raw_valid & raw_rdy):
  - Load the output register: valid=1, data=raw_data, sop=first_flag.
  - Clear first_flag; decrement words_left.
  - If words_left==1: eop=1, empty=last_empty, zero the low empty*8 data bits, go to BETWEEN_MSG. Else eop=0, empty=0.
- Output register:
  - Holds all fields stable while valid & ~rdy.
  - Clears valid on the rdy handshake when no new load happens in the same cycle.
  - A simultaneous drain and load is allowed: full throughput, one beat per cycle.
- Latency: one cycle from raw handshake to msg_out.valid. A length request is accepted no earlier than the cycle after the last raw handshake, so there is at least a one-cycle bubble between messages.
- rdy behaviour: msg_out.rdy may toggle freely; no beat is lost or duplicated.
- Single-beat messages: sop and eop are both 1.
- msg_out.valid never depends combinationally on msg_out.rdy.

Optional Feature:
- Macro: AVALON_PACKETIZER_MSG_CNT_EN.
- With the macro: adds output msg_cnt[31:0], which counts eop beats accepted downstream (valid & rdy & eop), wraps at 2^32, and resets to 0. Also adds output drop_cnt[15:0], which counts zero/oversize drops and saturates at 16'hFFFF.
- Without the macro: neither port nor the counter logic exists.

Decomposition:
- Package avalon_pkg holds:
  - msg_sm_t {IN_MSG, BETWEEN_MSG}, shared with the receive-side checker.
  - Function calc_empty(len), returning the last-beat empty.
  - Function calc_words(len).
- One sub-module: avalon_st_out_reg, the single-entry output register with valid/rdy hold, reused by other Avalon sources.

Test Plan (DATA_WIDTH_IN_BYTES=16):
- len=16, one raw word 0x00..0F, rdy=1 -> one beat: sop=1, eop=1, empty=0, data unchanged.
- len=37, three raw words of 0xAA, rdy=1 -> beats sop/eop = 1/0, 0/0, 0/1; last empty=11 with bytes[10:0]=0 and bytes[15:11]=0xAA.
- len=48 with rdy low for 5 cycles at beat 2 -> beat 2 held stable, raw_rdy=0 after register fills, beat 3 follows; exactly 3 beats total.
- len=0, then len=4097 -> zero_len_indi then oversize_indi, each high 1 cycle; msg_out.valid stays 0; raw_rdy stays 0.
- Back-to-back len=16 then len=32, rdy=1 -> 3 beats with sops on beats 1 and 2 and eops on beats 1 and 3; exactly one bubble between messages.
- rst low after beat 2 of a 4-beat message -> all outputs 0 next cycle; new len=16 afterwards yields a clean sop/eop beat. With AVALON_PACKETIZER_MSG_CNT_EN, msg_cnt=1.
